// File: rtl/booth_mul_arbiter_pkg.sv
// booth_arb_pkg: shared types and constants for the Booth multiplier arbiter.
//   arb_state_t : arbiter FSM states
//   DEF_*       : default parameter values
//   prod_w()    : product width for a given operand width
package booth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: request, core and response signals of the arbiter.
//   req_valid/req_a/req_b -> req_ready        : per-requester handshake
//   mul_start/mul_a/mul_b -> mul_done/product : multiplier core side
//   resp_valid/id/product/err <- resp_ready   : response handshake
//   busy                                      : arbiter not idle
// Modports: slave = the arbiter, master = clients plus core.
interface booth_mul_arbiter_if
  import booth_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int PW = prod_w(WIDTH);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0]            req_ready;

  logic                        mul_start;
  logic [WIDTH-1:0]            mul_a;
  logic [WIDTH-1:0]            mul_b;
  logic                        mul_done;
  logic [PW-1:0]               mul_product;

  logic                        resp_valid;
  logic                        resp_ready;
  logic [IW-1:0]               resp_id;
  logic [PW-1:0]               resp_product;
  logic                        resp_err;

  logic                        busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_product, resp_ready,
    output req_ready, mul_start, mul_a, mul_b,
           resp_valid, resp_id, resp_product, resp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_product, resp_ready,
    input  req_ready, mul_start, mul_a, mul_b,
           resp_valid, resp_id, resp_product, resp_err, busy
  );

endinterface

// File: rtl/booth_mul_arbiter_rr_select.sv
// rr_select: combinational round-robin priority selector.
//   req      : request vector
//   ptr      : highest-priority index this cycle
//   grant    : one-hot winner (zero when no request)
//   grant_id : winner index
//   any      : at least one request present
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_id,
  output logic             any
);

  logic [IW-1:0] idx;

  // Walk from the farthest offset to the nearest so the last hit, the one
  // closest to ptr, is the one that sticks.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one Booth multiplier core among N_REQ requesters.
// Requests are granted round-robin, the core is launched with the granted
// operands, completion is awaited under a watchdog, and the product is
// returned tagged with the requester index.
//   clk, rst : clock, synchronous active-high reset
//   bus      : booth_mul_arbiter_if.slave (requests, core, response, busy)
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                rst,
  booth_mul_arbiter_if.slave bus
);

  localparam int PW = prod_w(WIDTH);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_t       state, state_nxt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    grant_id;
  logic [N_REQ-1:0] sel_grant;
  logic [IW-1:0]    sel_id;
  logic             sel_any;
  logic [WIDTH-1:0] op_a, op_b;
  logic [CW-1:0]    wdog;
  logic [PW-1:0]    result;
  logic             err;
  logic             accept;
  logic             resp_fire;
  logic             wdog_exp;

  rr_select #(.N_REQ(N_REQ)) u_sel (
    .req      (bus.req_valid),
    .ptr      (ptr),
    .grant    (sel_grant),
    .grant_id (sel_id),
    .any      (sel_any)
  );

  // Last WAIT cycle: counter starts at 0 in the first WAIT cycle, so the
  // response lands TIMEOUT+1 cycles after mul_start.
  assign wdog_exp = (wdog == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.mul_start  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.busy       = 1'b1;
    accept         = 1'b0;
    resp_fire      = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        // A grant during reset would be lost, so never advertise one.
        if (sel_any && !rst) begin
          bus.req_ready = sel_grant;
          accept        = 1'b1;
          state_nxt     = LAUNCH;
        end
      end
      LAUNCH: begin
        bus.mul_start = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (bus.mul_done || wdog_exp) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          resp_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      grant_id <= '0;
      op_a     <= '0;
      op_b     <= '0;
      wdog     <= '0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        op_a     <= bus.req_a[sel_id];
        op_b     <= bus.req_b[sel_id];
        grant_id <= sel_id;
      end

      if (state == LAUNCH)    wdog <= '0;
      else if (state == WAIT) wdog <= wdog + CW'(1);

      // Result is only ever latched in WAIT; done pulses elsewhere are stray.
      // Done has priority over an expiring watchdog.
      if (state == WAIT) begin
        if (bus.mul_done) begin
          result <= bus.mul_product;
          err    <= 1'b0;
        end else if (wdog_exp) begin
          result <= '0;
          err    <= 1'b1;
        end
      end

      if (resp_fire)
        ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
    end
  end

  assign bus.mul_a        = op_a;
  assign bus.mul_b        = op_b;
  assign bus.resp_id      = grant_id;
  assign bus.resp_product = result;
  assign bus.resp_err     = err;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: randomized and directed bench with a transaction-level
// reference model and a per-cycle compare process.
module tb_booth_mul_arbiter;
  import booth_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int T  = 64;
  localparam int PW = 16;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mul_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  booth_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // stimulus knobs
  bit         rnd_mode    = 0;
  bit         withdraw_en = 0;
  bit [N-1:0] cont        = '0;
  bit [N-1:0] once        = '0;
  logic [W-1:0] dir_a [N];
  logic [W-1:0] dir_b [N];
  int  lat_fixed = 5;
  bit  lat_rand  = 0;
  bit  rr_rand   = 0;
  bit  rr_force  = 1;
  bit  stray_en  = 0;

  // reference model state
  bit           m_free = 1;
  int           m_ptr  = 0;
  bit           m_pend = 0;
  bit           m_res  = 0;
  int           m_start = -100;
  int           m_resp_cyc = 0;
  int           m_id = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [PW-1:0] m_prod = '0;
  bit           m_err = 0;
  int           core_at = -1;
  logic [PW-1:0] core_prod = '0;
  bit [N-1:0]   granted = '0;

  typedef struct {
    int id; logic [PW-1:0] prod; bit err; int start; int rcyc;
    int did; logic [PW-1:0] dprod; bit derr;
  } rsp_t;
  rsp_t rsp_log[$];
  int   gnt_log[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j[IW-1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic int pick_lat();
    int r;
    if (!lat_rand) return lat_fixed;
    r = $urandom_range(99);
    if (r < 10) return 0;
    if (r < 15) return T;
    return $urandom_range(20, 1);
  endfunction

  // driver: inputs change 1 time unit after the rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        bus.req_valid[i] = 1'b0;
        granted[i] = 1'b0;
        once[i] = 1'b0;
      end else if (bus.req_valid[i]) begin
        if (rnd_mode ? (withdraw_en && $urandom_range(99) < 4) : !(cont[i] || once[i]))
          bus.req_valid[i] = 1'b0;
      end else if (rnd_mode ? ($urandom_range(99) < 30) : (cont[i] || once[i])) begin
        bus.req_valid[i] = 1'b1;
        bus.req_a[i] = rnd_mode ? W'($urandom) : dir_a[i];
        bus.req_b[i] = rnd_mode ? W'($urandom) : dir_b[i];
      end
    end
    if (core_at == cyc) begin
      bus.mul_done = 1'b1;
      bus.mul_product = core_prod;
    end else if (stray_en && (m_free || m_res) && $urandom_range(99) < 40) begin
      bus.mul_done = 1'b1;
      bus.mul_product = PW'($urandom);
    end else begin
      bus.mul_done = 1'b0;
      bus.mul_product = PW'($urandom);
    end
    bus.resp_ready = rr_rand ? ($urandom_range(99) < 60) : rr_force;
  end

  // compare + model advance, away from the active edge
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic signed [PW-1:0] sa, sb;
    int  w, lat;
    bit  exp_start, exp_rv;
    rsp_t r;
    if (rst) begin
      m_free = 1; m_ptr = 0; m_pend = 0; m_res = 0;
      m_a = '0; m_b = '0; core_at = -1;
    end else begin
      exp_rdy = '0;
      w = m_free ? rr_pick(bus.req_valid, m_ptr) : -1;
      if (w >= 0) exp_rdy[w[IW-1:0]] = 1'b1;
      exp_start = m_pend && !m_res && (cyc == m_start);
      exp_rv    = m_res && (cyc >= m_resp_cyc);
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("mul_start", bus.mul_start, exp_start);
      chk("busy", bus.busy, !m_free);
      chk("resp_valid", bus.resp_valid, exp_rv);
      chk("mul_a", bus.mul_a, m_a);
      chk("mul_b", bus.mul_b, m_b);
      if (exp_rv) begin
        chk("resp_id", bus.resp_id, m_id);
        chk("resp_product", bus.resp_product, m_prod);
        chk("resp_err", bus.resp_err, m_err);
      end
      if (w >= 0) begin
        m_free = 0; m_pend = 1; m_res = 0;
        m_start = cyc + 1; m_id = w;
        m_a = bus.req_a[w[IW-1:0]];
        m_b = bus.req_b[w[IW-1:0]];
        granted[w[IW-1:0]] = 1'b1;
        gnt_log.push_back(w);
        sa = $signed(m_a); sb = $signed(m_b);
        core_prod = sa * sb;
        lat = pick_lat();
        core_at = (lat > 0) ? m_start + lat : -1;
      end else if (m_pend && !m_res && cyc > m_start) begin
        if (bus.mul_done) begin
          m_res = 1; m_resp_cyc = cyc + 1; m_prod = bus.mul_product; m_err = 0;
        end else if (cyc == m_start + T) begin
          m_res = 1; m_resp_cyc = cyc + 1; m_prod = '0; m_err = 1;
        end
      end
      if (exp_rv && bus.resp_ready) begin
        r.id = m_id; r.prod = m_prod; r.err = m_err; r.start = m_start; r.rcyc = m_resp_cyc;
        r.did = int'(bus.resp_id); r.dprod = bus.resp_product; r.derr = bus.resp_err;
        rsp_log.push_back(r);
        m_ptr = (m_id + 1) % N;
        m_free = 1; m_pend = 0; m_res = 0;
      end
    end
  end

  task automatic wait_rsp(input int k, input string nm);
    int g = 0;
    while (rsp_log.size() < k && g < 3000) begin @(posedge clk); g++; end
    if (rsp_log.size() < k) chk(nm, rsp_log.size(), k);
  endtask

  task automatic wait_gnt(input int k, input string nm);
    int g = 0;
    while (gnt_log.size() < k && g < 3000) begin @(posedge clk); g++; end
    if (gnt_log.size() < k) chk(nm, gnt_log.size(), k);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    dir_a[i] = a; dir_b[i] = b; once[i] = 1'b1;
  endtask

  initial begin
    int base, nr, g;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    bus.mul_done = 1'b0; bus.mul_product = '0; bus.resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin dir_a[i] = '0; dir_b[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_product", bus.resp_product, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_resp_id", bus.resp_id, 0);

    // single requester, 17-cycle core
    lat_fixed = 17;
    post(1, 8'd3, 8'd5);
    wait_rsp(1, "t1_timeout");
    chk("t1_id", rsp_log[0].did, 1);
    chk("t1_prod", rsp_log[0].dprod, 16'h000F);
    chk("t1_model_prod", rsp_log[0].prod, 16'h000F);
    chk("t1_err", rsp_log[0].derr, 0);
    chk("t1_resp_delay", rsp_log[0].rcyc - rsp_log[0].start, 18);

    // signed operands
    lat_fixed = 3;
    post(2, 8'hFD, 8'd5);
    wait_rsp(2, "t2_timeout");
    chk("t2_prod", rsp_log[1].dprod, 16'hFFF1);
    chk("t2_err", rsp_log[1].derr, 0);

    // all four continuous from reset: order 0,1,2,3,0 then wrap with {1,3}
    lat_fixed = 4;
    for (int i = 0; i < N; i++) begin dir_a[i] = W'(i + 1); dir_b[i] = W'(i + 2); end
    cont = 4'b1111;
    pulse_rst();
    base = gnt_log.size();
    wait_gnt(base + 5, "t3_timeout_a");
    chk("t3_g0", gnt_log[base + 0], 0);
    chk("t3_g1", gnt_log[base + 1], 1);
    chk("t3_g2", gnt_log[base + 2], 2);
    chk("t3_g3", gnt_log[base + 3], 3);
    chk("t3_g4", gnt_log[base + 4], 0);
    wait_gnt(base + 8, "t3_timeout_b");
    cont = 4'b1010;
    wait_gnt(base + 9, "t3_timeout_c");
    chk("t3_wrap", gnt_log[base + 8], 1);
    cont = '0;
    g = 0;
    while ((rsp_log.size() != gnt_log.size() || !m_free) && g < 500) begin @(posedge clk); g++; end

    // watchdog: no done at all, then done on the final WAIT cycle
    nr = rsp_log.size();
    lat_fixed = 0;
    post(0, 8'd9, 8'd9);
    wait_rsp(nr + 1, "t4_timeout_a");
    chk("t4_to_delay", rsp_log[nr].rcyc - rsp_log[nr].start, 65);
    chk("t4_to_err", rsp_log[nr].derr, 1);
    chk("t4_to_prod", rsp_log[nr].dprod, 0);
    lat_fixed = T;
    post(1, 8'd7, 8'd9);
    wait_rsp(nr + 2, "t4_timeout_b");
    chk("t4_edge_delay", rsp_log[nr + 1].rcyc - rsp_log[nr + 1].start, 65);
    chk("t4_edge_err", rsp_log[nr + 1].derr, 0);
    chk("t4_edge_prod", rsp_log[nr + 1].dprod, 16'h003F);

    // back-pressure with stray done pulses and a competing request
    nr = rsp_log.size();
    lat_fixed = 5;
    rr_force = 0;
    post(2, 8'hFE, 8'h7F);
    g = 0;
    while (!m_res && g < 200) begin @(posedge clk); g++; end
    base = gnt_log.size();
    stray_en = 1;
    post(3, 8'd1, 8'd1);
    repeat (10) @(posedge clk);
    chk("t5_no_grant", gnt_log.size(), base);
    stray_en = 0;
    rr_force = 1;
    wait_rsp(nr + 2, "t5_timeout");
    chk("t5_id", rsp_log[nr].did, 2);
    chk("t5_prod", rsp_log[nr].dprod, 16'hFF02);
    chk("t5_next_id", rsp_log[nr + 1].did, 3);
    chk("t5_next_prod", rsp_log[nr + 1].dprod, 16'h0001);

    // reset during WAIT
    nr = rsp_log.size();
    base = gnt_log.size();
    lat_fixed = 0;
    post(1, 8'd4, 8'd4);
    wait_gnt(base + 1, "t6_timeout_a");
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", bus.busy, 0);
    chk("t6_resp_valid", bus.resp_valid, 0);
    chk("t6_mul_start", bus.mul_start, 0);
    chk("t6_req_ready", bus.req_ready, 0);
    chk("t6_mul_a", bus.mul_a, 0);
    chk("t6_resp_product", bus.resp_product, 0);
    chk("t6_resp_id", bus.resp_id, 0);
    lat_fixed = 2;
    post(3, 8'd2, 8'd3);
    post(2, 8'd3, 8'd3);
    wait_gnt(base + 2, "t6_timeout_b");
    chk("t6_first_grant", gnt_log[base + 1], 2);
    wait_rsp(nr + 2, "t6_timeout_c");
    chk("t6_discarded", rsp_log[nr].did, 2);

    // randomized traffic
    nr = rsp_log.size();
    rnd_mode = 1; withdraw_en = 1; lat_rand = 1; rr_rand = 1; stray_en = 1;
    g = 0;
    while (rsp_log.size() < nr + 40 && g < 20000) begin @(posedge clk); g++; end
    if (rsp_log.size() < nr + 40) chk("rand_timeout", rsp_log.size(), nr + 40);
    rnd_mode = 0; rr_rand = 0; rr_force = 1; stray_en = 0;
    g = 0;
    while ((rsp_log.size() != gnt_log.size() || !m_free) && g < 500) begin @(posedge clk); g++; end
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
